fifo_share_arbiter: RTL and testbench

Access scheduler that shares one 8-deep, 8-bit `FIFO_8` between two producers and two consumers. It tracks occupancy internally, so it never issues a write when the FIFO is full or a read when it is empty. It never asserts `wen` and `ren` in the same cycle. It sits directly in front of `FIFO_8`, drives that FIFO's `wen`/`ren`/`din`, and returns `dout` to the granted consumer.

---
 rtl/fifo_share_arbiter.sv | 140 ++++++++++++++
 tb/tb_fifo_share_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_share_arbiter.sv
// Purpose : shares one DEPTH-deep FIFO between two producers and two consumers,
//           granting at most one write or one read per cycle.
// Latency : grants are combinational; read data and rvalid arrive one cycle after rgnt.
// Backpressure: an ungranted requester simply holds its request and data. Writes are
//           blocked while full and reads while empty. Contention between writes and
//           reads alternates, and round-robin is used within each class.
// Ports   : clk/rst_n (async active-low, shared with the FIFO);
//           wreq*/wdata*/wgnt* producer side; rreq*/rgnt*/rvalid*/rdata consumer side;
//           fifo_wen/fifo_ren/fifo_din/fifo_dout/fifo_error attach to the FIFO;
//           count/full/empty expose occupancy; err_seen is a sticky FIFO error flag.
// Option  : define FIFO_ARB_ERR_STICKY_EN to build the sticky err_seen register;
//           otherwise err_seen is tied low and fifo_error is ignored.
module fifo_share_arbiter #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wreq0,
  input  logic                         wreq1,
  input  logic [WIDTH-1:0]             wdata0,
  input  logic [WIDTH-1:0]             wdata1,
  output logic                         wgnt0,
  output logic                         wgnt1,
  input  logic                         rreq0,
  input  logic                         rreq1,
  output logic                         rgnt0,
  output logic                         rgnt1,
  output logic                         rvalid0,
  output logic                         rvalid1,
  output logic [WIDTH-1:0]             rdata,
  output logic                         fifo_wen,
  output logic                         fifo_ren,
  output logic [WIDTH-1:0]             fifo_din,
  input  logic [WIDTH-1:0]             fifo_dout,
  input  logic                         fifo_error,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         err_seen
);

  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0] r_count;
  logic          r_wptr;     // preferred write port
  logic          r_rptr;     // preferred read port
  logic          r_last_wr;  // 1: last granted op was a write, 0: a read
  logic          r_rvalid0;
  logic          r_rvalid1;

  logic w_full;
  logic w_empty;
  logic w_wr_elig;
  logic w_rd_elig;
  logic w_do_wr;
  logic w_do_rd;
  logic w_wsel;
  logic w_rsel;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Grants are forced low while reset is held, even if requests are present.
  assign w_wr_elig = rst_n & (wreq0 | wreq1) & ~w_full;
  assign w_rd_elig = rst_n & (rreq0 | rreq1) & ~w_empty;

  // When both classes are eligible, take the class opposite to the last one.
  assign w_do_wr = w_wr_elig & (~w_rd_elig | ~r_last_wr);
  assign w_do_rd = w_rd_elig & ~w_do_wr;

  // Port choice: the preferred port if it requests, else the other one.
  assign w_wsel = r_wptr ? wreq1 : ~wreq0;
  assign w_rsel = r_rptr ? rreq1 : ~rreq0;

  assign wgnt0 = w_do_wr & ~w_wsel;
  assign wgnt1 = w_do_wr &  w_wsel;
  assign rgnt0 = w_do_rd & ~w_rsel;
  assign rgnt1 = w_do_rd &  w_rsel;

  assign fifo_wen = w_do_wr;
  assign fifo_ren = w_do_rd;
  assign fifo_din = wgnt0 ? wdata0 : (wgnt1 ? wdata1 : '0);

  assign rdata   = fifo_dout;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign count   = r_count;
  assign full    = w_full;
  assign empty   = w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_last_wr <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= rgnt0;
      r_rvalid1 <= rgnt1;
      if (w_do_wr) begin
        r_count   <= r_count + CW'(1);
        r_wptr    <= ~w_wsel;   // next preference goes to the port not served
        r_last_wr <= 1'b1;
      end else if (w_do_rd) begin
        r_count   <= r_count - CW'(1);
        r_rptr    <= ~w_rsel;
        r_last_wr <= 1'b0;
      end
    end
  end

`ifdef FIFO_ARB_ERR_STICKY_EN
  // r_err_armed masks fifo_error on the first posedge after reset release,
  // when the freshly reset FIFO may still report a stale error.
  logic r_err_armed;
  logic r_err_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_armed <= 1'b0;
      r_err_seen  <= 1'b0;
    end else begin
      r_err_armed <= 1'b1;
      if (fifo_error && r_err_armed) begin
        r_err_seen <= 1'b1;
      end
    end
  end

  assign err_seen = r_err_seen;
`else
  logic w_unused_err;
  assign w_unused_err = fifo_error;
  assign err_seen     = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_share_arbiter.sv
// Purpose : checks fifo_share_arbiter against a table of per-cycle grants and occupancy,
//           with an 8-deep FIFO model attached and a read-data scoreboard.
// Latency : inputs are driven 1 time unit after posedge; outputs are sampled at negedge.
// Backpressure: none in the bench; requests are held exactly as the vectors specify.
module tb_fifo_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wreq0 = 1'b0, wreq1 = 1'b0, rreq0 = 1'b0, rreq1 = 1'b0;
  logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
  logic       wgnt0, wgnt1, rgnt0, rgnt1, rvalid0, rvalid1;
  logic [7:0] rdata, fifo_din, fifo_dout;
  logic       fifo_wen, fifo_ren, full, empty, err_seen;
  logic [3:0] count;
  logic       tb_err = 1'b0;

`ifdef FIFO_ARB_ERR_STICKY_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  fifo_share_arbiter #(.DEPTH(8), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wreq0(wreq0), .wreq1(wreq1), .wdata0(wdata0), .wdata1(wdata1),
    .wgnt0(wgnt0), .wgnt1(wgnt1),
    .rreq0(rreq0), .rreq1(rreq1), .rgnt0(rgnt0), .rgnt1(rgnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .fifo_wen(fifo_wen), .fifo_ren(fifo_ren), .fifo_din(fifo_din),
    .fifo_dout(fifo_dout), .fifo_error(tb_err),
    .count(count), .full(full), .empty(empty), .err_seen(err_seen)
  );

  // Stand-in for the attached 8-deep FIFO.
  logic [7:0] mem [8];
  logic [2:0] m_wp, m_rp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wp <= 3'd0; m_rp <= 3'd0; fifo_dout <= 8'h00;
    end else begin
      if (fifo_wen) begin mem[m_wp] <= fifo_din; m_wp <= m_wp + 3'd1; end
      if (fifo_ren) begin fifo_dout <= mem[m_rp]; m_rp <= m_rp + 3'd1; end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected FIFO contents, and expected {port, data} read returns.
  logic [7:0] fifo_q [$];
  logic [8:0] rd_exp [$];

  always @(negedge clk) begin
    if (rst_n && (rvalid0 || rvalid1)) begin
      if (rd_exp.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rvalid_unexpected: got %b%b expected none at %0t", rvalid0, rvalid1, $time);
      end else begin
        logic [8:0] e;
        e = rd_exp.pop_front();
        chk("rvalid_port", {30'd0, rvalid0, rvalid1}, e[8] ? 32'd1 : 32'd2);
        chk("rdata", {24'd0, rdata}, {24'd0, e[7:0]});
      end
    end
  end

  // req = {wreq0, wreq1, rreq0, rreq1}; gnt = {wgnt0, wgnt1, rgnt0, rgnt1}; cnt = count in that cycle.
  typedef struct {
    bit         pre_rst;
    logic [3:0] req;
    logic [7:0] wd0;
    logic [7:0] wd1;
    logic [3:0] gnt;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(bit pr, logic [3:0] req, logic [7:0] d0, logic [7:0] d1,
                              logic [3:0] gnt, logic [3:0] cnt);
    vec_t v;
    v.pre_rst = pr; v.req = req; v.wd0 = d0; v.wd1 = d1; v.gnt = gnt; v.cnt = cnt;
    return v;
  endfunction

  task automatic do_reset(input logic err_at_release);
    rst_n = 1'b0;
    {wreq0, wreq1, rreq0, rreq1} = 4'b0000;
    wdata0 = 8'h00; wdata1 = 8'h00; tb_err = 1'b0;
    fifo_q.delete(); rd_exp.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grants", {28'd0, wgnt0, wgnt1, rgnt0, rgnt1}, 32'd0);
    chk("rst_state", {26'd0, count, full, empty}, 32'd1);
    chk("rst_rvalid_err", {29'd0, rvalid0, rvalid1, err_seen}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tb_err = err_at_release;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] din_exp;
    if (v.pre_rst) do_reset(1'b0);
    @(posedge clk);
    #1;
    {wreq0, wreq1, rreq0, rreq1} = v.req;
    wdata0 = v.wd0; wdata1 = v.wd1; tb_err = 1'b0;
    @(negedge clk);
    din_exp = v.gnt[3] ? v.wd0 : (v.gnt[2] ? v.wd1 : 8'h00);
    chk($sformatf("grants[%0d]", idx), {28'd0, wgnt0, wgnt1, rgnt0, rgnt1}, {28'd0, v.gnt});
    chk($sformatf("strobes[%0d]", idx), {30'd0, fifo_wen, fifo_ren},
        {30'd0, |v.gnt[3:2], |v.gnt[1:0]});
    chk($sformatf("count[%0d]", idx), {28'd0, count}, {28'd0, v.cnt});
    chk($sformatf("full_empty[%0d]", idx), {30'd0, full, empty},
        {30'd0, v.cnt == 4'd8, v.cnt == 4'd0});
    chk($sformatf("fifo_din[%0d]", idx), {24'd0, fifo_din}, {24'd0, din_exp});
    if (v.gnt[3]) fifo_q.push_back(v.wd0);
    if (v.gnt[2]) fifo_q.push_back(v.wd1);
    if ((v.gnt[1] || v.gnt[0]) && fifo_q.size() > 0)
      rd_exp.push_back({v.gnt[0], fifo_q.pop_front()});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // Write fill: 8 grants then blocked while full.
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(i == 0, 4'b1000, (i < 9) ? 8'(i + 1) : 8'd9, 8'h00,
                        (i < 8) ? 4'b1000 : 4'b0000, (i < 8) ? 4'(i) : 4'd8));
    // Read drain on port 1: 8 grants then blocked while empty.
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0, 4'b0001, 8'h00, 8'h00,
                        (i < 8) ? 4'b0001 : 4'b0000, (i < 8) ? 4'(8 - i) : 4'd0));
    // Write round-robin from reset.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(i == 0, 4'b1100, 8'hA0, 8'hB0, (i % 2 == 0) ? 4'b1000 : 4'b0100, 4'(i)));
    vecs.push_back(mk(0, 4'b1000, 8'hC0, 8'h00, 4'b1000, 4'd4));
    vecs.push_back(mk(0, 4'b0010, 8'h00, 8'h00, 4'b0010, 4'd5));
    // All four requesting at count 4, last op a read: W,R,W,R,W,R.
    vecs.push_back(mk(0, 4'b1111, 8'hD0, 8'hD1, 4'b0100, 4'd4));
    vecs.push_back(mk(0, 4'b1111, 8'hD0, 8'hD1, 4'b0001, 4'd5));
    vecs.push_back(mk(0, 4'b1111, 8'hD0, 8'hD1, 4'b1000, 4'd4));
    vecs.push_back(mk(0, 4'b1111, 8'hD0, 8'hD1, 4'b0010, 4'd5));
    vecs.push_back(mk(0, 4'b1111, 8'hD0, 8'hD1, 4'b0100, 4'd4));
    vecs.push_back(mk(0, 4'b1111, 8'hD0, 8'hD1, 4'b0001, 4'd5));
    // Refill to 8, then full with both classes pending grants the read.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 4'b1000, 8'(8'hE1 + i), 8'h00, 4'b1000, 4'(4 + i)));
    vecs.push_back(mk(0, 4'b1000, 8'hE5, 8'h00, 4'b0000, 4'd8));
    vecs.push_back(mk(0, 4'b1010, 8'hE5, 8'h00, 4'b0010, 4'd8));
    vecs.push_back(mk(0, 4'b1010, 8'hE5, 8'h00, 4'b1000, 4'd7));
    // Read round-robin.
    vecs.push_back(mk(0, 4'b0011, 8'h00, 8'h00, 4'b0001, 4'd8));
    vecs.push_back(mk(0, 4'b0011, 8'h00, 8'h00, 4'b0010, 4'd7));
    vecs.push_back(mk(0, 4'b0000, 8'h00, 8'h00, 4'b0000, 4'd6));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Mid-operation reset while a read return is pending.
    do_reset(1'b0);
    run_vec(mk(0, 4'b1000, 8'h55, 8'h00, 4'b1000, 4'd0), 100);
    run_vec(mk(0, 4'b0010, 8'h00, 8'h00, 4'b0010, 4'd1), 101);
    @(posedge clk);
    #1;
    {wreq0, wreq1, rreq0, rreq1} = 4'b0000;
    chk("midrst_rvalid_pre", {31'd0, rvalid0}, 32'd1);
    #1;
    rst_n = 1'b0;
    fifo_q.delete(); rd_exp.delete();
    #1;
    chk("midrst_rvalid", {31'd0, rvalid0}, 32'd0);
    chk("midrst_state", {26'd0, count, full, empty}, 32'd1);
    {wreq0, wreq1, rreq0, rreq1} = 4'b1111;
    #1;
    chk("midrst_grants", {26'd0, wgnt0, wgnt1, rgnt0, rgnt1, fifo_wen, fifo_ren}, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_hold", {22'd0, count, wgnt0, wgnt1, rgnt0, rgnt1, fifo_wen, fifo_ren}, 32'd0);

    // Sticky error: ignored on the first posedge after release, then latched.
    do_reset(1'b1);
    run_vec(mk(0, 4'b0000, 8'h00, 8'h00, 4'b0000, 4'd0), 200);
    chk("err_ignored_after_rst", {31'd0, err_seen}, 32'd0);
    tb_err = 1'b1;
    run_vec(mk(0, 4'b0000, 8'h00, 8'h00, 4'b0000, 4'd0), 201);
    chk("err_set", {31'd0, err_seen}, {31'd0, EXP_ERR});
    run_vec(mk(0, 4'b0000, 8'h00, 8'h00, 4'b0000, 4'd0), 202);
    run_vec(mk(0, 4'b0000, 8'h00, 8'h00, 4'b0000, 4'd0), 203);
    chk("err_sticky", {31'd0, err_seen}, {31'd0, EXP_ERR});
    do_reset(1'b0);

    chk("reads_delivered", rd_exp.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
